// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and baud divider helper for the parametrised UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  // Rounded clocks per oversample tick.
  function automatic int tick_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick for one cycle on wrap.
module uart_baud_tick import uart_pkg::*; #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART with configurable frame format, valid/ready handshakes and
// oversampled RX with false-start rejection and parity/framing/overrun flags.
module uart_xcvr_param import uart_pkg::*; #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVS);
  localparam int TW = $clog2(OVS);
  localparam int BW = 4;
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);

  // ---------------- TX ----------------
  tx_state_e            tx_state, tx_state_n;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [TW-1:0]        tx_tcnt;
  logic [BW-1:0]        tx_bit;
  logic                 tx_tick, tx_accept, tx_bit_end;

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_accept  = tx_ready && tx_valid;
  assign tx_bit_end = tx_tick && (tx_tcnt == T_LAST);

  // TX divider restarts on accept so the start bit is exactly one bit period long.
  uart_baud_tick #(.DIV(TICK_DIV)) u_tx_tick (
    .clk(clk), .rst(rst), .clr(tx_accept), .tick(tx_tick)
  );

  always_comb begin
    tx_state_n = tx_state;
    tx_out     = 1'b1;
    case (tx_state)
      TX_IDLE:   if (tx_valid) tx_state_n = TX_START;
      TX_START: begin
        tx_out = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_out = tx_shift[0];
        if (tx_bit_end && tx_bit == D_LAST) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_out = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && tx_bit == S_LAST) tx_state_n = TX_IDLE;
      default:   tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_par   <= (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
        tx_tcnt  <= '0;
        tx_bit   <= '0;
      end else if (tx_tick) begin
        tx_tcnt <= (tx_tcnt == T_LAST) ? '0 : tx_tcnt + 1'b1;
        if (tx_bit_end) begin
          if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
          tx_bit <= (tx_state_n != tx_state) ? '0 : tx_bit + 1'b1;
        end
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e            rx_state, rx_state_n;
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_tick, rx_samp, rx_done, rx_perr_n, rx_par_bit;
  logic [TW-1:0]        rx_tcnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;

  assign rx_s = rx_sync[1];

  uart_baud_tick #(.DIV(TICK_DIV)) u_rx_tick (
    .clk(clk), .rst(rst), .clr(1'b0), .tick(rx_tick)
  );

  // Start bit is confirmed half a bit in; every later sample lands on a bit centre.
  assign rx_samp   = rx_tick && (rx_tcnt == ((rx_state == RX_START) ? T_HALF : T_LAST));
  assign rx_done   = rx_samp && (rx_state == RX_STOP);
  assign rx_perr_n = HAS_PAR &&
                     (rx_par_bit != ((PARITY == PARITY_ODD) ? ~^rx_shift : ^rx_shift));

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_s) rx_state_n = RX_START;
      RX_START:  if (rx_samp) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_samp && rx_bit == D_LAST) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_samp) rx_state_n = RX_STOP;
      RX_STOP:   if (rx_samp) rx_state_n = rx_s ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (rx_s) rx_state_n = RX_IDLE;
      default:   rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state      <= RX_IDLE;
      rx_sync       <= 2'b11;
      rx_tcnt       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_in};
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE || rx_state == RX_BREAK) rx_tcnt <= '0;
      else if (rx_tick) rx_tcnt <= rx_samp ? '0 : rx_tcnt + 1'b1;
      if (rx_samp) begin
        case (rx_state)
          RX_START:  rx_bit <= '0;
          RX_DATA: begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 1'b1;
          end
          RX_PARITY: rx_par_bit <= rx_s;
          default: ;
        endcase
      end
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      // A completion coinciding with the consumer handshake is loaded, not dropped.
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          rx_parity_err <= rx_perr_n;
          rx_frame_err  <= !rx_s;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
